// File: rtl/ram_pkg.sv
// Shared types, default sizes and the parity helper for the initialised dual-port RAM.
package ram_pkg;

  typedef enum logic {CLEAR, READY} state_t;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 8;

  // Even parity: the stored bit makes byte plus parity hold an even count of ones.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/ram_dp_init.sv
// Simple dual-port RAM with byte enables and a post-reset zero sweep.
// Optional per-byte even parity is enabled by defining RAM_PARITY_EN.
module ram_dp_init
  import ram_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int NB     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic [NB-1:0]     be,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              busy,
  output logic              par_err
);

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0] data_out_q;
  logic              rd_valid_q;

  logic              wr_fire, rd_fire, fwd;
  logic [DATA_W-1:0] rd_word;

  assign wr_fire = (state_q == READY) && en && we;
  assign rd_fire = (state_q == READY) && en && re;
  // Same-address write in the read cycle: forward the freshly written bytes.
  assign fwd     = wr_fire && (wr_addr == rd_addr);

  for (genvar gi = 0; gi < NB; gi++) begin : g_rd_byte
    assign rd_word[gi*8 +: 8] = (fwd && be[gi]) ? data_in[gi*8 +: 8]
                                                : mem[rd_addr][gi*8 +: 8];
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == ADDR_W'(DEPTH - 1)) state_d = READY;
      end
      READY: ;
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR;
      clr_cnt_q  <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      rd_valid_q <= rd_fire;
      if (rd_fire) data_out_q <= rd_word;
    end
  end

  // Storage carries no reset; the sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int b = 0; b < NB; b++) begin
        if (state_q == CLEAR)
          mem[clr_cnt_q][b*8 +: 8] <= 8'h00;
        else if (wr_fire && be[b])
          mem[wr_addr][b*8 +: 8] <= data_in[b*8 +: 8];
      end
    end
  end

`ifdef RAM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] rd_par, par_mis;
  logic          par_err_q;

  for (genvar gi = 0; gi < NB; gi++) begin : g_rd_par
    assign rd_par[gi]  = (fwd && be[gi]) ? byte_parity(data_in[gi*8 +: 8])
                                         : par_mem[rd_addr][gi];
    assign par_mis[gi] = rd_par[gi] ^ byte_parity(rd_word[gi*8 +: 8]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int b = 0; b < NB; b++) begin
        if (state_q == CLEAR)
          par_mem[clr_cnt_q][b] <= 1'b0;
        else if (wr_fire && be[b])
          par_mem[wr_addr][b] <= byte_parity(data_in[b*8 +: 8]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) par_err_q <= 1'b0;
    else     par_err_q <= rd_fire && (|par_mis);
  end

  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign busy     = (state_q == CLEAR);

endmodule

// File: tb/tb_ram_dp_init.sv
// Scoreboard bench for ram_dp_init (DATA_W=16, DEPTH=8): reads push expected words,
// a monitor pops and compares whenever rd_valid is seen.
module tb_ram_dp_init;

  logic        clk = 1'b0;
  logic        rst, en, we, re;
  logic [2:0]  wr_addr, rd_addr;
  logic [15:0] data_in;
  logic [1:0]  be;
  logic [15:0] data_out;
  logic        rd_valid, busy, par_err;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q [$];
  int n_busy;

  always #5 clk = ~clk;

  ram_dp_init #(.DATA_W(16), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .we(we), .wr_addr(wr_addr),
    .data_in(data_in), .be(be), .re(re), .rd_addr(rd_addr),
    .data_out(data_out), .rd_valid(rd_valid), .busy(busy), .par_err(par_err)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic w, input logic [2:0] wa,
                      input logic [15:0] d, input logic [1:0] b, input logic rr,
                      input logic [2:0] ra);
    rst = r; en = e; we = w; wr_addr = wa; data_in = d; be = b; re = rr; rd_addr = ra;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 2'b00, 1'b0, 3'd0);
  endtask

  // Read with optional same-cycle write; the expected word is queued for the monitor.
  task automatic rd(input logic [2:0] ra, input logic [15:0] exp,
                    input logic w, input logic [2:0] wa, input logic [15:0] d,
                    input logic [1:0] b);
    exp_q.push_back(exp);
    step(1'b0, 1'b1, w, wa, d, b, 1'b1, ra);
  endtask

  task automatic wr(input logic [2:0] wa, input logic [15:0] d, input logic [1:0] b);
    step(1'b0, 1'b1, 1'b1, wa, d, b, 1'b0, 3'd0);
  endtask

  // Counts busy cycles while hammering the inputs, which CLEAR must ignore.
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      step(1'b0, 1'b1, 1'b1, 3'd1, 16'hFFFF, 2'b11, 1'b1, 3'd1);
    end
  endtask

  initial begin
    step(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 2'b00, 1'b0, 3'd0);

    fork
      forever begin
        @(negedge clk);
        if (rd_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rd_valid actual=%h required=none", data_out);
          end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            $display("read data_out=%h expected=%h par_err=%b", data_out, e, par_err);
            chk("rd_data", data_out, e);
            chk("par_err_on_read", {15'd0, par_err}, 16'd0);
          end
        end else if (par_err) begin
          checks++;
          failures++;
          $display("FAIL par_err_idle actual=1 required=0");
        end
      end
    join_none

    step(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 2'b00, 1'b0, 3'd0);
    chk("reset_busy", {15'd0, busy}, 16'd1);
    chk("reset_rd_valid", {15'd0, rd_valid}, 16'd0);
    chk("reset_data_out", data_out, 16'h0000);
    chk("reset_par_err", {15'd0, par_err}, 16'd0);

    count_busy(n_busy);
    chk("sweep_len", 16'(n_busy), 16'd8);

    for (int a = 0; a < 8; a++) rd(3'(a), 16'h0000, 1'b0, 3'd0, 16'h0, 2'b00);

    wr(3'd5, 16'd42, 2'b01);
    rd(3'd5, 16'h002A, 1'b0, 3'd0, 16'h0, 2'b00);

    wr(3'd2, 16'hABCD, 2'b11);
    wr(3'd2, 16'h1234, 2'b01);
    rd(3'd2, 16'hAB34, 1'b0, 3'd0, 16'h0, 2'b00);

    rd(3'd3, 16'h0077, 1'b1, 3'd3, 16'h0077, 2'b11);
    rd(3'd3, 16'h5577, 1'b1, 3'd3, 16'h5566, 2'b10);

    rd(3'd5, 16'h002A, 1'b1, 3'd6, 16'h9999, 2'b11);
    rd(3'd6, 16'h9999, 1'b0, 3'd0, 16'h0, 2'b00);

    step(1'b0, 1'b0, 1'b1, 3'd5, 16'hFFFF, 2'b11, 1'b1, 3'd5);
    chk("en0_rd_valid", {15'd0, rd_valid}, 16'd0);
    chk("en0_data_hold", data_out, 16'h9999);
    rd(3'd5, 16'h002A, 1'b0, 3'd0, 16'h0, 2'b00);
    idle();
    chk("noread_rd_valid", {15'd0, rd_valid}, 16'd0);
    chk("noread_data_hold", data_out, 16'h002A);

    step(1'b1, 1'b1, 1'b0, 3'd0, 16'h0000, 2'b00, 1'b1, 3'd2);
    chk("rst_ready_rd_valid", {15'd0, rd_valid}, 16'd0);
    chk("rst_ready_data_out", data_out, 16'h0000);
    chk("rst_ready_busy", {15'd0, busy}, 16'd1);
    count_busy(n_busy);
    chk("resweep_len", 16'(n_busy), 16'd8);
    rd(3'd2, 16'h0000, 1'b0, 3'd0, 16'h0, 2'b00);
    rd(3'd6, 16'h0000, 1'b0, 3'd0, 16'h0, 2'b00);

    wr(3'd4, 16'hBEEF, 2'b11);
    step(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 2'b00, 1'b0, 3'd0);
    for (int i = 0; i < 4; i++) idle();
    step(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 2'b00, 1'b0, 3'd0);
    count_busy(n_busy);
    chk("midclear_sweep_len", 16'(n_busy), 16'd8);
    rd(3'd4, 16'h0000, 1'b0, 3'd0, 16'h0, 2'b00);

    idle();
    idle();
    chk("queue_drained", 16'(exp_q.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_dp_init.md
RAM_DP_INIT -- requirements
Module: ram_dp_init

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter DATA_W SHALL default to 8 and give the word width in bits; it SHALL be a multiple of 8.
REQ-003 Parameter DEPTH SHALL default to 8 and give the number of words; it SHALL be a power of two, 2 or more.
REQ-004 Localparam ADDR_W SHALL equal $clog2(DEPTH), and localparam NB SHALL equal DATA_W/8.
REQ-005 Port clk SHALL be an input, 1 bit: the rising-edge clock.
REQ-006 Port rst SHALL be an input, 1 bit: synchronous active-high reset.
REQ-007 Port en SHALL be an input, 1 bit: global enable, which gates both read and write.
REQ-008 Port we SHALL be an input, 1 bit: write request.
REQ-009 Port wr_addr SHALL be an input, ADDR_W bits: write address.
REQ-010 Port data_in SHALL be an input, DATA_W bits: write data.
REQ-011 Port be SHALL be an input, NB bits: byte enables, where bit i covers data_in[8i+7:8i].
REQ-012 Port re SHALL be an input, 1 bit: read request.
REQ-013 Port rd_addr SHALL be an input, ADDR_W bits: read address.
REQ-014 Port data_out SHALL be an output, DATA_W bits: registered read data.
REQ-015 Port rd_valid SHALL be an output, 1 bit: data_out is valid this cycle.
REQ-016 Port busy SHALL be an output, 1 bit: the initialisation sweep is in progress.
REQ-017 Port par_err SHALL be an output, 1 bit: parity mismatch on the current read.

Function
REQ-018 The FSM SHALL have two states: CLEAR and READY.
REQ-019 CLEAR SHALL write all-zero data (and correct parity) to address clr_cnt once per cycle, then increment clr_cnt.
REQ-020 When clr_cnt equals DEPTH-1, the FSM SHALL move to READY on the next edge; CLEAR lasts exactly DEPTH cycles.
REQ-021 busy SHALL be 1 in CLEAR and 0 in READY.
REQ-022 In CLEAR, we, re and en SHALL be ignored and rd_valid SHALL stay 0.
REQ-023 A write SHALL occur in READY when en=1 and we=1: byte i of mem[wr_addr] takes data_in byte i only where be[i]=1; other bytes keep their value.
REQ-024 A read SHALL occur in READY when en=1 and re=1: data_out takes mem[rd_addr] one cycle later, and rd_valid=1 in that same cycle.
REQ-025 Read latency SHALL be exactly 1 cycle.
REQ-026 When no read is issued, rd_valid SHALL be 0 next cycle and data_out SHALL hold its last value.
REQ-027 On a same-cycle read and write to the same address, the read SHALL return write-first data: new bytes where be=1, old bytes elsewhere.
REQ-028 A same-cycle read and write to different addresses SHALL both complete independently.
REQ-029 When en=0, the memory array and data_out SHALL be unchanged and rd_valid SHALL be 0 next cycle.
REQ-030 Addresses SHALL be used modulo DEPTH, with no out-of-range condition.

Reset
REQ-031 With rst=1 at an edge: state becomes CLEAR, clr_cnt=0, data_out=0, rd_valid=0, par_err=0, busy=1.
REQ-032 Reset asserted mid-CLEAR SHALL restart the sweep from address 0.
REQ-033 Reset asserted mid-READY SHALL discard any read in flight and re-clear all words.

Configuration
REQ-034 Macro RAM_PARITY_EN SHALL control parity.
REQ-035 With RAM_PARITY_EN defined, the array SHALL store one even-parity bit per byte, written alongside each written byte (per be), and recomputed on read.
REQ-036 With RAM_PARITY_EN defined, par_err SHALL be 1 exactly in cycles where rd_valid=1 and any stored parity bit mismatches; otherwise par_err=0.
REQ-037 Without RAM_PARITY_EN, no parity storage SHALL exist and par_err SHALL be tied to 0; the port list SHALL be identical in both builds.

Structure
REQ-038 Package ram_pkg SHALL hold typedef enum state_t {CLEAR, READY}, default parameter constants (DATA_W_DEF=8, DEPTH_DEF=8), and function byte_parity.
REQ-039 The design SHALL be a single module with no sub-module; the storage array, FSM and clear counter SHALL sit in ram_dp_init.

Verification
REQ-040 Reset, then hold 8 cycles with DEPTH=8 -> busy=1 for 8 cycles then 0; reads of addresses 0..7 return 0 with rd_valid=1.
REQ-041 Write 8'd42 to address 5 with be=1, then read address 5 -> data_out=42 and rd_valid=1 one cycle after the read request.
REQ-042 DATA_W=16: write 16'hABCD to address 2, then write 16'h1234 with be=2'b01, then read -> 16'hAB34.
REQ-043 In one cycle, write 8'h77 to address 3 and read address 3 (old value 0) -> data_out=8'h77 next cycle.
REQ-044 Assert rst at clr_cnt=4, or issue a read with en=0 -> sweep restarts (busy=1 for 8 cycles); with en=0, rd_valid=0 and data_out holds.
REQ-045 RAM_PARITY_EN defined: write then read any value -> par_err=0 on every rd_valid cycle; undefined -> par_err constantly 0.
